// File: rtl/player_cmd_decoder_if.sv
// player_cmd_decoder_if: scan-byte input bus and per-player command outputs of player_cmd_decoder
interface player_cmd_decoder_if;
    logic       en;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       flush;
    logic       p1_move_left;
    logic       p1_move_right;
    logic       p1_jump;
    logic       p1_smash;
    logic       p2_move_left;
    logic       p2_move_right;
    logic       p2_jump;
    logic       p2_smash;
    logic       cmd_valid;
    modport master (
        output en, scan_code, scan_valid, flush,
        input  p1_move_left, p1_move_right, p1_jump, p1_smash,
        input  p2_move_left, p2_move_right, p2_jump, p2_smash, cmd_valid
    );
    modport slave (
        input  en, scan_code, scan_valid, flush,
        output p1_move_left, p1_move_right, p1_jump, p1_smash,
        output p2_move_left, p2_move_right, p2_jump, p2_smash, cmd_valid
    );
endinterface

// File: rtl/player_cmd_decoder.sv
// player_cmd_decoder: PS/2 Set-2 bytes to frame-stable player commands; CMD_STICKY_EN latches sub-frame taps
module player_cmd_decoder #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TO_W           = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    player_cmd_decoder_if.slave  bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_EXT     = 2'd1;
    localparam logic [1:0] S_BRK     = 2'd2;
    localparam logic [1:0] S_EXT_BRK = 2'd3;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [1:0]      r_state, w_nxt;
    logic [TO_W-1:0] r_to;
    logic [7:0]      r_held, r_cmd, w_pend, w_src, w_snap, w_key, w_make, w_break;
    logic            r_cmd_valid, w_evt, w_brk, w_ext;
    always_comb begin
        w_nxt = r_state;
        w_evt = 1'b0;
        w_brk = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.scan_code == 8'hE0) w_nxt = S_EXT;
                else if (bus.scan_code == 8'hF0) w_nxt = S_BRK;
                else w_evt = 1'b1;
            end
            S_EXT: begin
                if (bus.scan_code == 8'hF0) w_nxt = S_EXT_BRK;
                else if (bus.scan_code != 8'hE0) begin
                    w_evt = 1'b1;
                    w_nxt = S_IDLE;
                end
            end
            default: begin
                w_evt = 1'b1;
                w_brk = 1'b1;
                w_nxt = S_IDLE;
            end
        endcase
    end
    assign w_ext = (r_state == S_EXT) || (r_state == S_EXT_BRK);
    always_comb begin
        w_key = 8'h00;
        if (!w_ext) begin
            case (bus.scan_code)
                8'h1C:   w_key[0] = 1'b1;
                8'h23:   w_key[1] = 1'b1;
                8'h1D:   w_key[2] = 1'b1;
                8'h1B:   w_key[3] = 1'b1;
                default: w_key = 8'h00;
            endcase
        end else begin
            case (bus.scan_code)
                8'h6B:   w_key[4] = 1'b1;
                8'h74:   w_key[5] = 1'b1;
                8'h75:   w_key[6] = 1'b1;
                8'h72:   w_key[7] = 1'b1;
                default: w_key = 8'h00;
            endcase
        end
    end
    assign w_make  = (bus.scan_valid && !bus.flush && w_evt && !w_brk) ? w_key : 8'h00;
    assign w_break = (bus.scan_valid && !bus.flush && w_evt && w_brk) ? w_key : 8'h00;
    assign w_src   = r_held | w_pend;
    // Holding both directions of one player cancels movement; jump/smash pass through.
    assign w_snap  = {w_src[7:6], w_src[5:4] & {2{~&w_src[5:4]}},
                      w_src[3:2], w_src[1:0] & {2{~&w_src[1:0]}}};
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_to        <= '0;
            r_held      <= '0;
            r_cmd       <= '0;
            r_cmd_valid <= 1'b0;
        end else begin
            r_cmd_valid <= bus.en;
            if (bus.en) r_cmd <= w_snap;
            if (bus.flush) begin
                r_state <= S_IDLE;
                r_to    <= '0;
                r_held  <= '0;
            end else if (bus.scan_valid) begin
                r_state <= w_nxt;
                r_to    <= '0;
                r_held  <= (r_held | w_make) & ~w_break;
            end else if (r_state != S_IDLE) begin
                r_state <= (r_to == TO_LAST) ? S_IDLE : r_state;
                r_to    <= (r_to == TO_LAST) ? '0 : r_to + TO_W'(1);
            end
        end
    end
`ifdef CMD_STICKY_EN
    logic [7:0] r_pend;
    always_ff @(posedge clk) begin
        if (rst || bus.flush) r_pend <= '0;
        else r_pend <= (bus.en ? 8'h00 : r_pend) | w_make;
    end
    assign w_pend = r_pend;
`else
    assign w_pend = 8'h00;
`endif
    assign bus.p1_move_left  = r_cmd[0];
    assign bus.p1_move_right = r_cmd[1];
    assign bus.p1_jump       = r_cmd[2];
    assign bus.p1_smash      = r_cmd[3];
    assign bus.p2_move_left  = r_cmd[4];
    assign bus.p2_move_right = r_cmd[5];
    assign bus.p2_jump       = r_cmd[6];
    assign bus.p2_smash      = r_cmd[7];
    assign bus.cmd_valid     = r_cmd_valid;
endmodule

// File: doc/player_cmd_decoder.md
# player_cmd_decoder

Converts the PS/2 Set-2 scan-code byte stream from the keyboard byte receiver into the eight per-player command levels consumed by the physics engine. It tracks make/break/extended prefixes and keeps a live held-key map. Once per frame, on the 60 Hz `en` tick, it publishes a registered command snapshot so physics sees inputs that are stable for the whole frame. It sits between the PS/2 byte receiver and `physic`.

## Interface
- `TIMEOUT_CYCLES`, default 100000: idle cycles after which a partial prefix sequence is abandoned.
- `TO_W`, default 17: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.
- `clk` in 1: system clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: one-cycle frame tick at 60 Hz, the same strobe that drives physics.
- `scan_code` in 8: received byte, valid only when `scan_valid` is high.
- `scan_valid` in 1: one-cycle strobe per received byte.
- `flush` in 1: clears all held and pending key state, e.g. on game over.
- `p1_move_left`, `p1_move_right`, `p1_jump`, `p1_smash` out 1 each: P1 command levels, registered.
- `p2_move_left`, `p2_move_right`, `p2_jump`, `p2_smash` out 1 each: P2 command levels, registered.
- `cmd_valid` out 1: one-cycle pulse, the cycle after a snapshot update.

## Operation
- **Key map (Set 2).**
  - P1: left=`1C` (A), right=`23` (D), jump=`1D` (W), smash=`1B` (S). These are non-extended only.
  - P2: left=`E0 6B`, right=`E0 74`, jump=`E0 75`, smash=`E0 72`. These are extended only.
  - A non-extended `6B` does not match P2, and an extended `1C` does not match P1.
- **Prefix FSM.** It advances only on `scan_valid`.
  - IDLE: `E0` goes to EXT. `F0` goes to BRK. Any other byte is a make event for that code, and the state stays IDLE.
  - EXT: `F0` goes to EXT_BRK. `E0` stays in EXT. Any other byte is an extended make, then the state returns to IDLE.
  - BRK: any byte is a non-extended break, then IDLE.
  - EXT_BRK: any byte is an extended break, then IDLE.
  - `E1`, `FA`, `AA`, `EE`, `FE`, `00` and `FF` received in IDLE are ignored, and the state stays IDLE.
  - Bytes that do not map to a command change no key state.
- **Held map.** The held map is an 8-bit register, `held`.
  - A make sets its bit.
  - A break clears its bit.
  - Typematic repeat makes are idempotent.
- **Snapshot on `en`.**
  - `src = held | pend`, where `pend` is defined under Configuration.
  - For each player: if both left and right are set in `src`, both outputs are 0. Otherwise each output equals its `src` bit.
  - Jump and smash pass through unmodified.
  - Outputs change only on `en` cycles.
- **Timeout.** The counter resets on every `scan_valid`. In any non-IDLE state it increments each cycle. When it reaches `TIMEOUT_CYCLES - 1` the FSM returns to IDLE and no key event is generated. The counter holds at 0 while the FSM is in IDLE.
- **Flush.** `held`, `pend` and the FSM clear (FSM to IDLE) on the same edge. Outputs are not touched until the next `en`. Flush has priority over a same-cycle `scan_valid`, whose byte is discarded.

## Timing
- **Reset values.** All eight command outputs are 0 and `cmd_valid` is 0. `held`, `pend` and the timeout counter are 0, and the FSM is IDLE.
- **Byte effect.** A byte updates `held` on the edge where `scan_valid` is high.
- **Command latency.** A snapshot taken at `en` edge N uses the values of `held` and `pend` from before that edge. If `en` and `scan_valid` occur in the same cycle, that byte is reflected at the following `en`.
- **Frame latency.** Physics samples on its next `en`, so command-to-physics latency is 1 frame.
- **`cmd_valid`.** It is high exactly in the cycle after each `en`, and asserts regardless of whether the outputs changed.
- **Throughput.** Back-to-back `scan_valid` on consecutive cycles is supported at one byte per cycle.

## Configuration
- **`CMD_STICKY_EN` defined.** `pend` is an 8-bit register.
  - Each make sets its `pend` bit.
  - `en` clears `pend`.
  - A make in the same cycle as `en` sets its bit after the clear, so set wins.
  - A tap that is pressed and released within one frame is therefore still reported for exactly one frame.
- **`CMD_STICKY_EN` not defined.** `pend` is constant 0, so the snapshot uses `held` only and sub-frame taps can be lost.

## Test plan
- **Basic make/break.** Send `1D` and pulse `en`. Then `p1_jump`=1 and `cmd_valid` pulses one cycle later. Send `F0 1D` and pulse `en`. Then `p1_jump`=0.
- **Extended keys.** Send `E0 74` and pulse `en`: `p2_move_right`=1 and P1 is unchanged. Send `74` alone: no P2 change.
- **Left/right cancel.** Hold `1C` and `23`, then pulse `en`. Both P1 move outputs are 0. Send `F0 1C` and pulse `en`: `p1_move_right`=1.
- **Sub-frame tap.** Send `1B`, then `F0 1B`, then pulse `en`. With `CMD_STICKY_EN`, `p1_smash`=1 for one frame and 0 after the next `en`. Without it, `p1_smash` stays 0.
- **Timeout.** Send `E0`, wait `TIMEOUT_CYCLES` cycles, then send `75` and pulse `en`. `p2_jump`=0 because the timeout abandoned the prefix. With `CMD_STICKY_EN`, `p1_jump` is also 0, since `75` does not match P1.
- **Reset and flush mid-sequence.** Send `E0 F0`, then assert `rst` for one cycle, then send `6B`. No key state changes and all outputs are 0. Separately, hold `1C`, assert `flush`, then pulse `en`: `p1_move_left`=0.
